// File: rtl/argmax_pkg.sv
// Shared types and defaults for the argmax sequencer.
// Provides the FSM state encoding, default sizing constants and an index-width helper.
// Optional build macro used by the block: ARGMAX_SIGNED_EN (signed score comparison).
package argmax_pkg;

    // Sequencer states: waiting for start, streaming scores, presenting result.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } argmax_state_t;

    localparam int ARGMAX_DATA_W      = 32;
    localparam int ARGMAX_NUM_CLASSES = 10;

    // Index width for a given class count; never narrower than one bit.
    function automatic int argmax_idx_w(input int num_classes);
        return (num_classes > 1) ? $clog2(num_classes) : 1;
    endfunction

endpackage

// File: rtl/argmax_cmp_stage.sv
// Combinational compare-and-select of the running (max, idx) against a new (score, index).
// Ports: cur_max/cur_idx = tracked best, cand_data/cand_idx = incoming beat, first = first beat of run;
//        nxt_max/nxt_idx = updated best, take = candidate wins. Zero latency, no flow control.
// ARGMAX_SIGNED_EN selects two's-complement comparison; otherwise scores are unsigned.
module argmax_cmp_stage
    import argmax_pkg::*;
#(
    parameter int DATA_W = ARGMAX_DATA_W,
    parameter int IDX_W  = argmax_idx_w(ARGMAX_NUM_CLASSES)
) (
    input  logic [DATA_W-1:0] cur_max,
    input  logic [IDX_W-1:0]  cur_idx,
    input  logic [DATA_W-1:0] cand_data,
    input  logic [IDX_W-1:0]  cand_idx,
    input  logic              first,
    output logic [DATA_W-1:0] nxt_max,
    output logic [IDX_W-1:0]  nxt_idx,
    output logic              take
);

    logic greater;

    // Strict compare: an equal score never displaces the earlier index.
`ifdef ARGMAX_SIGNED_EN
    assign greater = $signed(cand_data) > $signed(cur_max);
`else
    assign greater = cand_data > cur_max;
`endif

    // The first beat of a run always loads, discarding whatever the previous run left behind.
    assign take    = first | greater;
    assign nxt_max = take ? cand_data : cur_max;
    assign nxt_idx = take ? cand_idx  : cur_idx;

endmodule

// File: rtl/argmax_sequencer.sv
// Sequenced N-way argmax: streams NUM_CLASSES scores over valid/ready and returns the winning index.
// Ports: start/abort control; in_valid/in_ready/in_data score stream; res_valid/res_ready/res_idx/res_max
//        result; busy = not IDLE. Result valid 1 cycle after the last beat; holds until res_ready.
// Build macro ARGMAX_SIGNED_EN switches score comparison to signed (carried by argmax_cmp_stage).
module argmax_sequencer
    import argmax_pkg::*;
#(
    parameter int DATA_W      = ARGMAX_DATA_W,
    parameter int NUM_CLASSES = ARGMAX_NUM_CLASSES,
    parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDX_W-1:0]  res_idx,
    output logic [DATA_W-1:0] res_max,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    argmax_state_t     state;
    logic [IDX_W-1:0]  count;
    logic [DATA_W-1:0] max_q;
    logic [IDX_W-1:0]  idx_q;

    logic              beat;
    logic [DATA_W-1:0] nxt_max;
    logic [IDX_W-1:0]  nxt_idx;
    logic              take;

    // in_ready is a registered copy of (state == COLLECT), so it is a valid handshake term.
    assign beat = in_valid & in_ready;

    argmax_cmp_stage #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_cmp (
        .cur_max   (max_q),
        .cur_idx   (idx_q),
        .cand_data (in_data),
        .cand_idx  (count),
        .first     (count == '0),
        .nxt_max   (nxt_max),
        .nxt_idx   (nxt_idx),
        .take      (take)
    );

    // The tracking registers are the result: they keep the last answer until the next run's first beat.
    assign res_idx = idx_q;
    assign res_max = max_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            max_q     <= '0;
            idx_q     <= '0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (abort) begin
            // Flush wins over start, beats and the result handshake; no result is emitted.
            state     <= IDLE;
            count     <= '0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= COLLECT;
                        count    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                COLLECT: begin
                    if (beat) begin
                        if (take) begin
                            max_q <= nxt_max;
                            idx_q <= nxt_idx;
                        end
                        if (count == LAST_IDX) begin
                            // Count parks on the last index so it cannot wrap when
                            // NUM_CLASSES is a power of two.
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            res_valid <= 1'b1;
                        end else begin
                            count <= count + IDX_W'(1);
                        end
                    end
                end

                DONE: begin
                    // start is deliberately not looked at here, even alongside res_ready.
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    count     <= '0;
                    in_ready  <= 1'b0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_sequencer.sv
// Self-checking bench for argmax_sequencer: directed and randomized score runs against a reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
// The reference model follows ARGMAX_SIGNED_EN when the bench is built with it.
module tb_argmax_sequencer;

    localparam int N = 10;
    localparam int W = 32;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          res_valid;
    logic          res_ready;
    logic [IW-1:0] res_idx;
    logic [W-1:0]  res_max;
    logic          busy;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] vec [N];

    argmax_sequencer #(
        .DATA_W      (W),
        .NUM_CLASSES (N),
        .IDX_W       (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_idx   (res_idx),
        .res_max   (res_max),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Score ordering as seen by the classifier.
    function automatic bit beats(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef ARGMAX_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    // Reference: find the largest score, then the first position that holds it.
    task automatic model(output logic [W-1:0] best, output int where);
        best = vec[0];
        foreach (vec[i]) if (beats(vec[i], best)) best = vec[i];
        where = -1;
        for (int i = N - 1; i >= 0; i--) if (vec[i] == best) where = i;
    endtask

    task automatic load_basic();
        vec[0] = 3;  vec[1] = 9; vec[2] = 1;  vec[3] = 7; vec[4] = 20;
        vec[5] = 4;  vec[6] = 20; vec[7] = 0; vec[8] = 5; vec[9] = 2;
    endtask

    // One full run: start, N beats with optional stalls, result held 'hold' cycles, then accepted.
    task automatic do_run(input string tag, input int gap, input bit rnd_gap, input int hold,
                          input bit poke_start);
        logic [W-1:0] emax;
        int           eidx;
        int           g;
        model(emax, eidx);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        for (int i = 0; i < N; i++) begin
            g = (i == 0) ? 0 : (rnd_gap ? int'($urandom_range(gap, 0)) : gap);
            in_valid = 1'b0;
            repeat (g) begin
                in_data = $urandom;
                @(negedge clk);
                check({tag, "_stall_ready"}, 64'(in_ready), 64'd1);
            end
            in_valid = 1'b1;
            in_data  = vec[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        check({tag, "_res_valid"}, 64'(res_valid), 64'd1);
        check({tag, "_ready_low"}, 64'(in_ready), 64'd0);
        check({tag, "_res_idx"}, 64'(res_idx), 64'(eidx));
        check({tag, "_res_max"}, 64'(res_max), 64'(emax));
        repeat (hold) begin
            start = poke_start;
            @(negedge clk);
            start = 1'b0;
            check({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
            check({tag, "_hold_idx"}, 64'(res_idx), 64'(eidx));
            check({tag, "_hold_max"}, 64'(res_max), 64'(emax));
        end
        res_ready = 1'b1;
        start     = poke_start;
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        check({tag, "_idle_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_kept_idx"}, 64'(res_idx), 64'(eidx));
        check({tag, "_kept_max"}, 64'(res_max), 64'(emax));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; res_ready = 1'b0;

        // Reset and idle with no start.
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_res_max", 64'(res_max), 64'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            @(negedge clk);
            check("idle_in_ready", 64'(in_ready), 64'd0);
            check("idle_res_valid", 64'(res_valid), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_res_idx", 64'(res_idx), 64'd0);
        end
        in_valid = 1'b0;

        // Basic run with a tie on the maximum: earliest index wins.
        load_basic();
        do_run("basic", 0, 1'b0, 0, 1'b0);
        check("basic_idx_const", 64'(res_idx), 64'd4);
        check("basic_max_const", 64'(res_max), 64'd20);

        // Same data with 3-cycle stalls and 5 cycles of result backpressure; start pokes ignored.
        do_run("stall", 3, 1'b0, 5, 1'b1);
        check("stall_idx_const", 64'(res_idx), 64'd4);

        // Abort after four beats, coincident with a fifth offered beat.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'd100 + W'(i);
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        repeat (5) begin
            @(negedge clk);
            check("abort_no_result", 64'(res_valid), 64'd0);
        end
        foreach (vec[i]) vec[i] = W'(i);
        do_run("post_abort", 0, 1'b0, 1, 1'b0);
        check("post_abort_idx", 64'(res_idx), 64'd9);
        check("post_abort_max", 64'(res_max), 64'd9);

        // All-negative scores: -1 at index 1 wins under either ordering.
        vec[0] = 32'hFFFF_FFFB;
        vec[1] = 32'hFFFF_FFFF;
        for (int i = 2; i < N; i++) vec[i] = 32'd0 - W'(i + 1);
        do_run("neg", 0, 1'b0, 0, 1'b0);
        check("neg_idx_const", 64'(res_idx), 64'd1);

        // 0 followed by -1: ordering decides the winner.
        foreach (vec[i]) vec[i] = '0;
        vec[1] = 32'hFFFF_FFFF;
        do_run("sign_sel", 0, 1'b0, 0, 1'b0);
`ifdef ARGMAX_SIGNED_EN
        check("sign_sel_const", 64'(res_idx), 64'd0);
`else
        check("sign_sel_const", 64'(res_idx), 64'd1);
`endif

        // All-equal scores return index 0.
        foreach (vec[i]) vec[i] = 32'd77;
        do_run("all_equal", 0, 1'b0, 0, 1'b0);
        check("all_equal_const", 64'(res_idx), 64'd0);

        // Randomized runs: narrow ranges force ties, full range exercises sign bits.
        for (int r = 0; r < 12; r++) begin
            foreach (vec[i]) vec[i] = r[0] ? W'($urandom_range(3, 0)) : W'($urandom);
            do_run("rand", 2, 1'b1, int'($urandom_range(3, 0)), (r % 3) == 0);
        end

        // Asynchronous reset in the middle of beat 6.
        foreach (vec[i]) vec[i] = W'($urandom_range(1000, 1));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = vec[i];
            @(negedge clk);
        end
        in_data = vec[6];
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        check("arst_res_valid", 64'(res_valid), 64'd0);
        check("arst_res_idx", 64'(res_idx), 64'd0);
        check("arst_res_max", 64'(res_max), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("arst_need_start", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        do_run("after_arst", 1, 1'b1, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
